fb_scanout_base_mapper: RTL and testbench

Read-address front end between the display scanout core and the memory AXI read port. Relocates every relative AR request from the scanout core by the currently active framebuffer base, with a full-throughput two-entry register slice on the AR path. Owns the swap handshake with the renderer and commits a new base either immediately or at the next frame boundary. Parametrised successor of the current DVI address glue: configurable widths, explicit `frame_start` instead of address-zero detection, pending-swap state, frame counter.

---
 rtl/fb_scanout_pkg.sv | 30 +++
 rtl/fb_ar_skid.sv | 66 ++++++
 rtl/fb_scanout_base_mapper.sv | 122 ++++++++++++
 tb/tb_fb_scanout_base_mapper.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_scanout_pkg.sv
// Shared types and constants for the scanout base mapper: swap FSM states,
// reset base address and the AR payload layout carried through the slice.
package fb_scanout_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      DONE    = 2'd2
   } swap_state_e;

   localparam logic [31:0] FB_ADDR_DEFAULT_C = 32'h01E0_0000;

   localparam int AR_ADDR_W_C  = 32;
   localparam int AR_ID_W_C    = 4;
   localparam int AR_LEN_W_C   = 8;
   localparam int AR_BURST_W_C = 2;

   // Field order matches the packing used on the slice payload (addr in the MSBs).
   typedef struct packed {
      logic [AR_ADDR_W_C-1:0]  addr;
      logic [AR_ID_W_C-1:0]    id;
      logic [AR_LEN_W_C-1:0]   len;
      logic [AR_BURST_W_C-1:0] burst;
   } ar_payload_t;

   function automatic int ar_payload_width(input int addr_w, input int id_w);
      return addr_w + id_w + AR_LEN_W_C + AR_BURST_W_C;
   endfunction

endpackage

// File: rtl/fb_ar_skid.sv
// Two-entry AR register slice: an output register plus one skid entry, giving
// full throughput with a registered upstream ready.
module fb_ar_skid #(
   parameter int WIDTH = 46
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             skid_valid_q, skid_valid_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic             in_fire;

   assign in_ready = ~skid_valid_q;
   assign in_fire  = in_valid & ~skid_valid_q;

   // The output register always refills from the skid first, so order is kept
   // and the skid can only hold a beat while the output is stalled.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (!out_valid_q || out_ready) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
         end else if (in_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (in_fire) begin
         skid_valid_d = 1'b1;
         skid_data_d  = in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: rtl/fb_scanout_base_mapper.sv
// Scanout AR front end: relocates relative read addresses by the active
// framebuffer base and runs the renderer swap handshake that selects that base.
module fb_scanout_base_mapper
   import fb_scanout_pkg::*;
#(
   parameter int          ADDR_WIDTH      = 32,
   parameter int          ID_WIDTH        = 4,
   parameter logic [31:0] FB_ADDR_DEFAULT = FB_ADDR_DEFAULT_C
) (
   input  logic                  aclk,
   input  logic                  resetn,
   input  logic                  swap,
   input  logic                  enable_vsync,
   input  logic [ADDR_WIDTH-1:0] fbAddr,
   output logic                  swapped,
   input  logic                  frame_start,
   output logic [ADDR_WIDTH-1:0] active_base,
   output logic                  swap_pending,
   output logic [15:0]           frame_count,
   input  logic                  s_arvalid,
   output logic                  s_arready,
   input  logic [ADDR_WIDTH-1:0] s_araddr,
   input  logic [ID_WIDTH-1:0]   s_arid,
   input  logic [7:0]            s_arlen,
   input  logic [1:0]            s_arburst,
   output logic                  m_mem_axi_arvalid,
   input  logic                  m_mem_axi_arready,
   output logic [ADDR_WIDTH-1:0] m_mem_axi_araddr,
   output logic [ID_WIDTH-1:0]   m_mem_axi_arid,
   output logic [7:0]            m_mem_axi_arlen,
   output logic [1:0]            m_mem_axi_arburst
);

   localparam int PW = ar_payload_width(ADDR_WIDTH, ID_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] BASE_RESET_C = ADDR_WIDTH'(FB_ADDR_DEFAULT);

   swap_state_e           state_q, state_d;
   logic [ADDR_WIDTH-1:0] active_base_q, active_base_d;
   logic [ADDR_WIDTH-1:0] pending_base_q, pending_base_d;
   logic [15:0]           frame_count_q, frame_count_d;

   logic [PW-1:0]         in_payload;
   logic [PW-1:0]         out_payload;

   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A vsync swap also commits once enable_vsync is seen low while pending.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (swap) state_d = enable_vsync ? PENDING : DONE;
         PENDING: if (frame_start || !enable_vsync) state_d = DONE;
         DONE:    if (!swap) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      swapped      = (state_q == IDLE);
      swap_pending = (state_q == PENDING);
   end

   // Immediate swaps commit fbAddr directly because pending_base is only
   // being written on that same edge.
   always_comb begin
      active_base_d  = active_base_q;
      pending_base_d = pending_base_q;
      frame_count_d  = frame_count_q;
      if (state_q == IDLE && swap) begin
         pending_base_d = fbAddr;
         if (!enable_vsync) begin
            active_base_d = fbAddr;
            frame_count_d = frame_count_q + 16'd1;
         end
      end else if (state_q == PENDING && (frame_start || !enable_vsync)) begin
         active_base_d = pending_base_q;
         frame_count_d = frame_count_q + 16'd1;
      end
   end

   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         active_base_q  <= BASE_RESET_C;
         pending_base_q <= BASE_RESET_C;
         frame_count_q  <= 16'd0;
      end else begin
         active_base_q  <= active_base_d;
         pending_base_q <= pending_base_d;
         frame_count_q  <= frame_count_d;
      end
   end

   assign active_base = active_base_q;
   assign frame_count = frame_count_q;

   assign in_payload = {s_araddr + active_base_q, s_arid, s_arlen, s_arburst};

   fb_ar_skid #(
      .WIDTH(PW)
   ) u_ar_skid (
      .clk       (aclk),
      .rst_n     (resetn),
      .in_valid  (s_arvalid),
      .in_ready  (s_arready),
      .in_data   (in_payload),
      .out_valid (m_mem_axi_arvalid),
      .out_ready (m_mem_axi_arready),
      .out_data  (out_payload)
   );

   assign m_mem_axi_araddr  = out_payload[PW-1 -: ADDR_WIDTH];
   assign m_mem_axi_arid    = out_payload[AR_LEN_W_C+AR_BURST_W_C +: ID_WIDTH];
   assign m_mem_axi_arlen   = out_payload[AR_BURST_W_C +: AR_LEN_W_C];
   assign m_mem_axi_arburst = out_payload[AR_BURST_W_C-1:0];

endmodule

// File: tb/tb_fb_scanout_base_mapper.sv
// Directed bench for fb_scanout_base_mapper: swap handshake, relocation,
// AR slice backpressure, address wrap and asynchronous reset.
module tb_fb_scanout_base_mapper;

   logic        aclk;
   logic        resetn;
   logic        swap;
   logic        enable_vsync;
   logic [31:0] fbAddr;
   logic        swapped;
   logic        frame_start;
   logic [31:0] active_base;
   logic        swap_pending;
   logic [15:0] frame_count;
   logic        s_arvalid;
   logic        s_arready;
   logic [31:0] s_araddr;
   logic [3:0]  s_arid;
   logic [7:0]  s_arlen;
   logic [1:0]  s_arburst;
   logic        m_arvalid;
   logic        m_arready;
   logic [31:0] m_araddr;
   logic [3:0]  m_arid;
   logic [7:0]  m_arlen;
   logic [1:0]  m_arburst;

   int total = 0;
   int bad   = 0;

   logic [31:0] beat_addr[$];
   logic [3:0]  beat_id[$];

   fb_scanout_base_mapper dut (
      .aclk              (aclk),
      .resetn            (resetn),
      .swap              (swap),
      .enable_vsync      (enable_vsync),
      .fbAddr            (fbAddr),
      .swapped           (swapped),
      .frame_start       (frame_start),
      .active_base       (active_base),
      .swap_pending      (swap_pending),
      .frame_count       (frame_count),
      .s_arvalid         (s_arvalid),
      .s_arready         (s_arready),
      .s_araddr          (s_araddr),
      .s_arid            (s_arid),
      .s_arlen           (s_arlen),
      .s_arburst         (s_arburst),
      .m_mem_axi_arvalid (m_arvalid),
      .m_mem_axi_arready (m_arready),
      .m_mem_axi_araddr  (m_araddr),
      .m_mem_axi_arid    (m_arid),
      .m_mem_axi_arlen   (m_arlen),
      .m_mem_axi_arburst (m_arburst)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Record every memory-side handshake in order.
   always @(posedge aclk) begin
      if (resetn && m_arvalid && m_arready) begin
         beat_addr.push_back(m_araddr);
         beat_id.push_back(m_arid);
      end
   end

   task automatic tick;
      @(posedge aclk);
      #1;
   endtask

   task automatic test_reset;
      resetn = 1'b0; swap = 1'b0; enable_vsync = 1'b0; fbAddr = '0;
      frame_start = 1'b0; s_arvalid = 1'b0; s_araddr = '0; s_arid = '0;
      s_arlen = '0; s_arburst = '0; m_arready = 1'b1;
      repeat (3) tick();
      resetn = 1'b1;
      tick();
      total++; if (swapped !== 1'b1) begin bad++; $display("[TB] FAIL reset_swapped: got %b want 1", swapped); end
      total++; if (swap_pending !== 1'b0) begin bad++; $display("[TB] FAIL reset_pending: got %b want 0", swap_pending); end
      total++; if (active_base !== 32'h01E00000) begin bad++; $display("[TB] FAIL reset_base: got %h want 01e00000", active_base); end
      total++; if (frame_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d want 0", frame_count); end
      total++; if (s_arready !== 1'b1) begin bad++; $display("[TB] FAIL reset_s_arready: got %b want 1", s_arready); end
      total++; if (m_arvalid !== 1'b0 || m_araddr !== 32'h0) begin bad++; $display("[TB] FAIL reset_m_ar: got valid=%b addr=%h want 0/0", m_arvalid, m_araddr); end
   endtask

   task automatic test_immediate_swap;
      enable_vsync = 1'b0; fbAddr = 32'h02000000; swap = 1'b1;
      tick();
      total++; if (active_base !== 32'h02000000) begin bad++; $display("[TB] FAIL imm_base: got %h want 02000000", active_base); end
      total++; if (swapped !== 1'b0) begin bad++; $display("[TB] FAIL imm_swapped_low: got %b want 0", swapped); end
      total++; if (frame_count !== 16'd1) begin bad++; $display("[TB] FAIL imm_count: got %0d want 1", frame_count); end
      fbAddr = 32'hDEAD0000;
      tick(); tick();
      total++; if (active_base !== 32'h02000000 || swapped !== 1'b0 || frame_count !== 16'd1) begin
         bad++; $display("[TB] FAIL imm_hold: got base=%h swapped=%b count=%0d want 02000000/0/1", active_base, swapped, frame_count);
      end
      swap = 1'b0;
      tick();
      total++; if (swapped !== 1'b1) begin bad++; $display("[TB] FAIL imm_swapped_back: got %b want 1", swapped); end
   endtask

   task automatic test_vsync_swap;
      enable_vsync = 1'b1; fbAddr = 32'h03000000; swap = 1'b1;
      tick();
      total++; if (swap_pending !== 1'b1 || swapped !== 1'b0) begin bad++; $display("[TB] FAIL vs_pending: got pending=%b swapped=%b want 1/0", swap_pending, swapped); end
      fbAddr = 32'hBAD00000; swap = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick();
         total++; if (swap_pending !== 1'b1 || active_base !== 32'h02000000) begin
            bad++; $display("[TB] FAIL vs_wait cycle %0d: got pending=%b base=%h want 1/02000000", i, swap_pending, active_base);
         end
      end
      frame_start = 1'b1; s_arvalid = 1'b1; s_araddr = 32'h100; s_arid = 4'd5; s_arlen = 8'd3; s_arburst = 2'd1;
      tick();
      total++; if (active_base !== 32'h03000000 || frame_count !== 16'd2 || swap_pending !== 1'b0) begin
         bad++; $display("[TB] FAIL vs_commit: got base=%h count=%0d pending=%b want 03000000/2/0", active_base, frame_count, swap_pending);
      end
      total++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h02000100) begin bad++; $display("[TB] FAIL vs_old_base_ar: got valid=%b addr=%h want 1/02000100", m_arvalid, m_araddr); end
      total++; if (m_arid !== 4'd5 || m_arlen !== 8'd3 || m_arburst !== 2'd1) begin bad++; $display("[TB] FAIL vs_passthru: got id=%0d len=%0d burst=%0d want 5/3/1", m_arid, m_arlen, m_arburst); end
      frame_start = 1'b0; s_arid = 4'd6;
      tick();
      total++; if (m_araddr !== 32'h03000100 || m_arid !== 4'd6) begin bad++; $display("[TB] FAIL vs_new_base_ar: got addr=%h id=%0d want 03000100/6", m_araddr, m_arid); end
      total++; if (swapped !== 1'b1) begin bad++; $display("[TB] FAIL vs_swapped_back: got %b want 1", swapped); end
      s_arvalid = 1'b0;
      tick();
      total++; if (m_arvalid !== 1'b0) begin bad++; $display("[TB] FAIL vs_drain: got valid=%b want 0", m_arvalid); end
   endtask

   task automatic test_back_to_back;
      s_arvalid = 1'b1; m_arready = 1'b1; s_arlen = 8'd0; s_arburst = 2'd1;
      for (int i = 0; i < 4; i++) begin
         s_araddr = 32'(i * 16); s_arid = 4'(i);
         tick();
         total++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h03000000 + 32'(i * 16) || s_arready !== 1'b1) begin
            bad++; $display("[TB] FAIL b2b beat %0d: got valid=%b addr=%h ready=%b want 1/%h/1", i, m_arvalid, m_araddr, s_arready, 32'h03000000 + 32'(i * 16));
         end
      end
      s_arvalid = 1'b0;
      tick();
      total++; if (m_arvalid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_drain: got valid=%b want 0", m_arvalid); end
   endtask

   task automatic test_backpressure;
      logic [15:0] pattern;
      int          sent;
      int          start;
      int          occ;
      logic        stall;
      logic        acc;
      logic [31:0] held;
      pattern = 16'b0011_0100_1100_0101;
      sent    = 0;
      start   = beat_addr.size();
      for (int cyc = 0; cyc < 200 && (beat_addr.size() - start) < 8; cyc++) begin
         s_arvalid = (sent < 8);
         s_araddr  = 32'(sent * 32'h80);
         s_arid    = 4'(sent);
         m_arready = pattern[cyc % 16];
         occ = sent - (beat_addr.size() - start);
         total++; if (s_arready !== (occ < 2)) begin bad++; $display("[TB] FAIL bp_s_arready cycle %0d: got %b want %b", cyc, s_arready, (occ < 2)); end
         stall = m_arvalid && !m_arready;
         held  = m_araddr;
         acc   = s_arvalid && s_arready;
         tick();
         if (acc) sent++;
         if (stall) begin
            total++; if (m_arvalid !== 1'b1 || m_araddr !== held) begin
               bad++; $display("[TB] FAIL bp_stable cycle %0d: got valid=%b addr=%h want 1/%h", cyc, m_arvalid, m_araddr, held);
            end
         end
      end
      s_arvalid = 1'b0; m_arready = 1'b1;
      total++; if (beat_addr.size() - start != 8) begin bad++; $display("[TB] FAIL bp_count: got %0d want 8", beat_addr.size() - start); end
      for (int i = 0; i < 8 && start + i < beat_addr.size(); i++) begin
         total++; if (beat_addr[start+i] !== 32'h03000000 + 32'(i * 32'h80) || beat_id[start+i] !== 4'(i)) begin
            bad++; $display("[TB] FAIL bp_beat %0d: got addr=%h id=%0d want %h/%0d", i, beat_addr[start+i], beat_id[start+i], 32'h03000000 + 32'(i * 32'h80), i);
         end
      end
      tick();
   endtask

   task automatic test_vsync_drop;
      enable_vsync = 1'b1; fbAddr = 32'h04000000; swap = 1'b1;
      tick();
      total++; if (swap_pending !== 1'b1) begin bad++; $display("[TB] FAIL drop_pending: got %b want 1", swap_pending); end
      swap = 1'b0; enable_vsync = 1'b0;
      tick();
      total++; if (active_base !== 32'h04000000 || frame_count !== 16'd3) begin bad++; $display("[TB] FAIL drop_commit: got base=%h count=%0d want 04000000/3", active_base, frame_count); end
      tick();
      total++; if (swapped !== 1'b1) begin bad++; $display("[TB] FAIL drop_idle: got %b want 1", swapped); end
   endtask

   task automatic test_wrap;
      enable_vsync = 1'b0; fbAddr = 32'hFFFFFF00; swap = 1'b1;
      tick();
      swap = 1'b0;
      tick();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      total++; if (active_base !== 32'hFFFFFF00 || frame_count !== 16'd4) begin bad++; $display("[TB] FAIL wrap_base: got base=%h count=%0d want ffffff00/4", active_base, frame_count); end
      s_arvalid = 1'b1; s_araddr = 32'h200;
      tick();
      s_arvalid = 1'b0;
      total++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h00000100) begin bad++; $display("[TB] FAIL wrap_addr: got valid=%b addr=%h want 1/00000100", m_arvalid, m_araddr); end
      tick();
   endtask

   task automatic test_async_reset;
      int cnt;
      enable_vsync = 1'b1; fbAddr = 32'h05000000; swap = 1'b1;
      tick();
      swap = 1'b0; m_arready = 1'b0; s_arvalid = 1'b1; s_araddr = 32'h40;
      tick();
      s_araddr = 32'h80;
      tick();
      s_arvalid = 1'b0;
      total++; if (s_arready !== 1'b0 || swap_pending !== 1'b1) begin bad++; $display("[TB] FAIL ar_full_pending: got ready=%b pending=%b want 0/1", s_arready, swap_pending); end
      #2 resetn = 1'b0;
      #1;
      total++; if (swapped !== 1'b1 || swap_pending !== 1'b0 || active_base !== 32'h01E00000 || frame_count !== 16'd0) begin
         bad++; $display("[TB] FAIL ar_fsm: got swapped=%b pending=%b base=%h count=%0d want 1/0/01e00000/0", swapped, swap_pending, active_base, frame_count);
      end
      total++; if (m_arvalid !== 1'b0 || m_araddr !== 32'h0 || m_arid !== 4'd0 || s_arready !== 1'b1) begin
         bad++; $display("[TB] FAIL ar_slice: got valid=%b addr=%h id=%0d ready=%b want 0/0/0/1", m_arvalid, m_araddr, m_arid, s_arready);
      end
      m_arready = 1'b1;
      tick(); tick();
      resetn = 1'b1;
      cnt = beat_addr.size();
      repeat (10) tick();
      total++; if (beat_addr.size() != cnt || m_arvalid !== 1'b0) begin bad++; $display("[TB] FAIL ar_no_beat: got beats=%0d valid=%b want 0/0", beat_addr.size() - cnt, m_arvalid); end
   endtask

   initial begin
      test_reset();
      test_immediate_swap();
      test_vsync_swap();
      test_back_to_back();
      test_backpressure();
      test_vsync_drop();
      test_wrap();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
